// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the RV32M multiply/divide unit.
//   XLEN           operand/result width (only 32 is supported)
//   muldiv_op_t    Funct3 operation encoding
//   muldiv_state_t sequencer states
//   abs_if()       two's-complement magnitude of a value treated as signed or not
//   op_a_signed()  whether operand A of an op is interpreted as signed
//   op_b_signed()  whether operand B of an op is interpreted as signed
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER_COUNT = 32;
    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    // Divide ops: bit 0 clear means signed. Multiply: MULHU is the only
    // op with an unsigned A.
    function automatic logic op_a_signed(input muldiv_op_t op);
        logic [2:0] o;
        o = op;
        return o[2] ? ~o[0] : (op != OP_MULHU);
    endfunction

    // Multiply: only MUL and MULH treat B as signed.
    function automatic logic op_b_signed(input muldiv_op_t op);
        logic [2:0] o;
        o = op;
        return o[2] ? ~o[0] : (op == OP_MUL || op == OP_MULH);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// -----------------------------------------------------------------------------
// alu_muldiv_if
// Request/response bundle of the multiply/divide unit.
//   SrcA, SrcB, Funct3, Start   request from the core (master drives)
//   Busy, Done, Result, Illegal response from the unit (slave drives)
// -----------------------------------------------------------------------------
interface alu_muldiv_if;
    import muldiv_pkg::*;

    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [2:0]      Funct3;
    logic            Start;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;
    logic            Illegal;

    modport master (
        output SrcA, SrcB, Funct3, Start,
        input  Busy, Done, Result, Illegal
    );

    modport slave (
        input  SrcA, SrcB, Funct3, Start,
        output Busy, Done, Result, Illegal
    );

endinterface

// File: rtl/alu_div_core.sv
// -----------------------------------------------------------------------------
// alu_div_core
// Restoring divider on operand magnitudes, one quotient bit per step.
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture dividend/divisor (raw) and signedness
//   step                perform one restoring iteration
//   is_signed           operands are two's-complement signed
//   dividend, divisor   raw operands, sampled on load
//   quot, rem           unsigned quotient/remainder magnitudes
//   div_zero, div_ovf   captured boundary flags (divide by zero, INT_MIN/-1)
// -----------------------------------------------------------------------------
module alu_div_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            div_zero,
    output logic            div_ovf
);

    // quot_q starts holding the dividend magnitude; its MSB shifts into the
    // partial remainder each step while quotient bits shift in at the LSB.
    logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic            zero_q, zero_d, ovf_q, ovf_d;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            ge;

    always_comb begin
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        shifted = {rem_q, quot_q[XLEN-1]};
        ge      = shifted >= {1'b0, dvsr_q};
        // When ge holds the true difference is below the divisor, so 32 bits suffice.
        sub     = shifted[XLEN-1:0] - dvsr_q;
        if (load) begin
            quot_d = abs_if(dividend, is_signed);
            rem_d  = '0;
            dvsr_d = abs_if(divisor, is_signed);
            zero_d = (divisor == '0);
            ovf_d  = is_signed && (dividend == INT_MIN) && (divisor == '1);
        end else if (step) begin
            quot_d = {quot_q[XLEN-2:0], ge};
            rem_d  = ge ? sub : shifted[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = zero_q;
    assign div_ovf  = ovf_q;

endmodule

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Iterative RV32M multiply/divide unit with a fixed 34-cycle latency
// (32 CALC iterations, 1 FIX cycle, result presented in DONE).
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     alu_muldiv_if.slave: SrcA/SrcB/Funct3/Start in,
//           Busy/Done/Result/Illegal out
// Build option MULDIV_DIV_EN: when defined the divider (alu_div_core) is
// present and Illegal is tied low; when undefined, divide opcodes complete
// in one cycle with Done=Illegal=1 and Result=0.
// -----------------------------------------------------------------------------
module alu_muldiv
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);

    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    muldiv_state_t     state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    muldiv_op_t        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   result_q, result_d;

    muldiv_op_t        in_op;
    logic [XLEN:0]     add_sum;
    logic              a_neg, b_neg;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    assign in_op = muldiv_op_t'(bus.Funct3);
    assign a_neg = op_a_signed(op_q) & a_q[XLEN-1];
    assign b_neg = op_b_signed(op_q) & b_q[XLEN-1];

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] div_quot, div_rem;
    logic            div_zero, div_ovf;

    alu_div_core u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (bus.Start && (state_q == S_IDLE || state_q == S_DONE)),
        .step      (state_q == S_CALC),
        .is_signed (~bus.Funct3[0]),
        .dividend  (bus.SrcA),
        .divisor   (bus.SrcB),
        .quot      (div_quot),
        .rem       (div_rem),
        .div_zero  (div_zero),
        .div_ovf   (div_ovf)
    );
`else
    logic illegal_q, illegal_d;
`endif

    // Sign fix-up and result selection, consumed in FIX.
    always_comb begin
        prod_fix = (a_neg ^ b_neg) ? (~prod_q + 1'b1) : prod_q;
        fix_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        if (op_q == OP_DIV || op_q == OP_DIVU) begin
            if (div_zero)     fix_res = DIV0_QUOT;
            else if (div_ovf) fix_res = INT_MIN;
            else              fix_res = (a_neg ^ b_neg) ? (~div_quot + 1'b1) : div_quot;
        end else if (op_q == OP_REM || op_q == OP_REMU) begin
            if (div_zero)     fix_res = a_q;
            else if (div_ovf) fix_res = '0;
            else              fix_res = a_neg ? (~div_rem + 1'b1) : div_rem;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        result_d = result_q;
`ifndef MULDIV_DIV_EN
        illegal_d = illegal_q;
`endif
        // Shift-add: add the multiplicand into the upper half when the
        // multiplier LSB (held in the low half) is set, then shift right.
        add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    op_d    = in_op;
                    a_d     = bus.SrcA;
                    b_d     = bus.SrcB;
                    cnt_d   = '0;
                    mcand_d = abs_if(bus.SrcA, op_a_signed(in_op));
                    prod_d  = {{XLEN{1'b0}}, abs_if(bus.SrcB, op_b_signed(in_op))};
                    state_d = S_CALC;
`ifndef MULDIV_DIV_EN
                    illegal_d = 1'b0;
                    if (bus.Funct3[2]) begin
                        illegal_d = 1'b1;
                        result_d  = '0;
                        state_d   = S_DONE;
                    end
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                prod_d = {add_sum, prod_q[XLEN-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
`ifndef MULDIV_DIV_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            result_q <= result_d;
`ifndef MULDIV_DIV_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.Busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.Done   = (state_q == S_DONE);
    assign bus.Result = result_q;
`ifdef MULDIV_DIV_EN
    assign bus.Illegal = 1'b0;
`else
    assign bus.Illegal = (state_q == S_DONE) && illegal_q;
`endif

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative RV32M multiply/divide unit beside the main ALU, downstream of the ALU source-B mux. It takes the same SrcA/SrcB operands as the ALU and returns the M-extension result after a fixed multi-cycle latency. It drives a Busy stall to the core's PC/register-write enables while an operation is in flight.

## Interface
- XLEN, 32, operand/result width; only 32 is supported and verified.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- SrcA  input  XLEN  first operand: rs1 value.
- SrcB  input  XLEN  second operand, the ALU source-B mux output SrcB.
- Funct3  input  3  operation code:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Start  input  1  request; SrcA, SrcB and Funct3 are captured on the edge where Start=1 and the unit is idle.
- Busy  output  1  high while an operation is in progress; the core uses it as a stall.
- Done  output  1  one-cycle pulse when Result is valid.
- Result  output  XLEN  result; held stable until the next accepted Start.
- Illegal  output  1  one-cycle pulse alongside Done for an unsupported op. Driven only when the divider is compiled out (see Configuration).

## Operation
- Reset values: state IDLE, Busy=0, Done=0, Illegal=0, Result=0, iteration counter=0.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE/DONE + Start: capture operands and Funct3, clear counter, go to CALC.
  - CALC: one iteration per cycle. Leave CALC when the counter reaches 31.
  - FIX: apply sign correction, write Result, go to DONE.
  - DONE: Done=1 for one cycle. Then go to IDLE, or straight to CALC if Start=1.
- Multiply:
  - Operands are converted to magnitudes according to signedness (MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned).
  - 32-step shift-add into a 64-bit product.
  - In FIX, negate the product if the operand signs differ (signed ops only).
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - 32-step restoring division on magnitudes.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Boundary cases (handled in FIX, latency unchanged):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Start while Busy=1 is ignored; the in-flight operation and its Result are unaffected.
- Operand inputs may change freely after capture.
- Reset mid-operation: the asynchronous return to reset values aborts the operation and produces no Done. rst_n low together with Start: reset wins.

## Timing
- Start sampled high at the end of cycle N:
  - Busy=1 in cycles N+1 … N+33 (32 CALC cycles + 1 FIX).
  - Done=1 and Result valid in cycle N+34, with Busy=0.
- Fixed 34-cycle latency for every op, including the boundary cases.
- Back-to-back: Start asserted during DONE (cycle N+34) gives the next Done at N+68.
- Result is a registered output. Done, Busy and Illegal are decoded from registered state; there is no combinational path from any input.

## Configuration
- MULDIV_DIV_EN defined: the divider datapath is present, all eight Funct3 codes execute, and Illegal is tied to 0.
- MULDIV_DIV_EN undefined: the divider is omitted. A Start with Funct3[2]=1 goes IDLE→DONE:
  - Done=1 and Illegal=1 in cycle N+1.
  - Result=0.
  - Busy stays 0.
  - Multiply ops are unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - XLEN;
  - the Funct3 enum (muldiv_op_t);
  - the FSM state enum (muldiv_state_t);
  - constants ITER_COUNT=32, DIV0_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One sub-module, alu_div_core: restoring divider step, quotient/remainder registers and boundary detection. It is instantiated only under MULDIV_DIV_EN.
- The top level keeps the FSM, counter, multiplier and sign fix-up.

## Test plan
- MUL 7 × 0xFFFFFFFD, Start in cycle N → Busy high cycles N+1–N+33; Done in cycle N+34; Result 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. Each completes with Done at N+34.
- Start pulses at N+5 with different operands while busy → ignored; the original Result appears at N+34. rst_n low at N+10 → Busy=0 and Result=0 immediately, and no Done follows.
- MULDIV_DIV_EN undefined, DIV 10 / 2 → Done=1 and Illegal=1 in cycle N+1, Result=0. MUL 3 × 4 → 12 at N+34.
